// File: rtl/sw_mask_sched_pkg.sv
// Shared constants and FSM encoding for the capacitor select-mask scheduler.
package sw_mask_sched_pkg;

  localparam int CAP_NUM_DEF  = 128;
  localparam int CH_NUM_DEF   = 70;
  localparam int POP_STEP_DEF = 8;
  localparam int POP_W        = $clog2(CAP_NUM_DEF + 1);

  localparam logic [CAP_NUM_DEF-1:0] SW_RST_MASK =
    {{(CAP_NUM_DEF-CH_NUM_DEF){1'b0}}, {CH_NUM_DEF{1'b1}}};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COUNT,
    ST_BREAK,
    ST_APPLY,
    ST_SETTLE
  } state_e;

endpackage

// File: rtl/sw_mask_sched_popcnt.sv
// Serial popcount: POP_STEP bits per clock, LSB slice first. done/count are
// combinational on the last slice so the caller can branch on that same edge.
module popcnt_serial
  import sw_mask_sched_pkg::*;
#(
  parameter int CAP_NUM  = CAP_NUM_DEF,
  parameter int POP_STEP = POP_STEP_DEF,
  parameter int CNT_W    = $clog2(CAP_NUM + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [CAP_NUM-1:0] data,
  output logic               done,
  output logic [CNT_W-1:0]   count
);

  localparam int NSLICE = CAP_NUM / POP_STEP;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  logic [IDX_W-1:0]    idx_q;
  logic [CNT_W-1:0]    acc_q;
  logic                run_q;
  logic [POP_STEP-1:0] slice;
  logic [CNT_W-1:0]    slice_pop;

  assign slice = data[idx_q*POP_STEP +: POP_STEP];

  always_comb begin
    slice_pop = '0;
    for (int i = 0; i < POP_STEP; i++) slice_pop = slice_pop + CNT_W'(slice[i]);
  end

  assign count = acc_q + slice_pop;
  assign done  = run_q && (idx_q == IDX_W'(NSLICE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      acc_q <= '0;
      run_q <= 1'b0;
    end else if (start) begin
      idx_q <= '0;
      acc_q <= '0;
      run_q <= 1'b1;
    end else if (run_q) begin
      acc_q <= count;
      idx_q <= idx_q + 1'b1;
      if (done) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/sw_mask_sched.sv
// Owns the capacitor select mask: validates/commits new masks and rotates the
// active window in IDLE. Define SW_MASK_SCHED_BBM_EN for break-before-make.
module sw_mask_sched
  import sw_mask_sched_pkg::*;
#(
  parameter int CAP_NUM    = CAP_NUM_DEF,
  parameter int CH_NUM     = CH_NUM_DEF,
  parameter int POP_STEP   = POP_STEP_DEF,
  parameter int SETTLE_CYC = 4,
  parameter int PERIOD_W   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CAP_NUM-1:0]  cfg_mask,
  input  logic                rot_en,
  input  logic [PERIOD_W-1:0] rot_period,
  output logic [CAP_NUM-1:0]  sw,
  output logic                sw_update,
  output logic                cfg_err,
  output logic                busy
);

  localparam int CNT_W = $clog2(CAP_NUM + 1);
  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CAP_NUM-1:0] RST_MASK = {{(CAP_NUM-CH_NUM){1'b0}}, {CH_NUM{1'b1}}};

  state_e              state_q, state_d;
  logic [CAP_NUM-1:0]  shadow_q, shadow_d;
  logic [CAP_NUM-1:0]  sw_q, sw_d;
  logic                upd_q, upd_d;
  logic                err_q, err_d;
  logic [PERIOD_W-1:0] rot_q, rot_d;
  logic [SET_W-1:0]    set_q, set_d;

  logic                accept;
  logic                pc_done;
  logic [CNT_W-1:0]    pc_count;

  popcnt_serial #(
    .CAP_NUM (CAP_NUM),
    .POP_STEP(POP_STEP),
    .CNT_W   (CNT_W)
  ) u_popcnt (
    .clk  (clk),
    .rst_n(rst_n),
    .start(accept),
    .data (shadow_q),
    .done (pc_done),
    .count(pc_count)
  );

  assign cfg_ready = (state_q == ST_IDLE);
  assign accept    = cfg_valid && cfg_ready;
  assign busy      = (state_q != ST_IDLE);
  assign sw        = sw_q;
  assign sw_update = upd_q;
  assign cfg_err   = err_q;

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    sw_d     = sw_q;
    upd_d    = 1'b0;
    err_d    = 1'b0;
    rot_d    = '0;
    set_d    = set_q;
    case (state_q)
      ST_IDLE: begin
        // Accept beats a coincident rotation tick; counter restarts either way.
        if (accept) begin
          shadow_d = cfg_mask;
          state_d  = ST_COUNT;
        end else if (rot_en && (rot_period != '0)) begin
          if (rot_q >= PERIOD_W'(rot_period - 1'b1)) begin
            sw_d  = {sw_q[CAP_NUM-2:0], sw_q[CAP_NUM-1]};
            upd_d = 1'b1;
          end else begin
            rot_d = rot_q + 1'b1;
          end
        end
      end
      ST_COUNT: begin
        if (pc_done) begin
          if (pc_count == CNT_W'(CH_NUM)) begin
`ifdef SW_MASK_SCHED_BBM_EN
            state_d = ST_BREAK;
`else
            state_d = ST_APPLY;
`endif
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
`ifdef SW_MASK_SCHED_BBM_EN
      ST_BREAK: begin
        // Drop lines leaving the set before any new line is connected.
        sw_d    = sw_q & shadow_q;
        upd_d   = 1'b1;
        state_d = ST_APPLY;
      end
`endif
      ST_APPLY: begin
        sw_d    = shadow_q;
        upd_d   = 1'b1;
        set_d   = '0;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (set_q == SET_W'(SETTLE_CYC - 1)) begin
          set_d   = '0;
          state_d = ST_IDLE;
        end else begin
          set_d = set_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      shadow_q <= '0;
      sw_q     <= RST_MASK;
      upd_q    <= 1'b0;
      err_q    <= 1'b0;
      rot_q    <= '0;
      set_q    <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      sw_q     <= sw_d;
      upd_q    <= upd_d;
      err_q    <= err_d;
      rot_q    <= rot_d;
      set_q    <= set_d;
    end
  end

endmodule

// File: tb/tb_sw_mask_sched.sv
// Directed bench for sw_mask_sched: reset, commit, reject, rotation, priority, mid-count reset.
module tb_sw_mask_sched;

  localparam int CAP = 128;
`ifdef SW_MASK_SCHED_BBM_EN
  localparam int LAT = 18;
`else
  localparam int LAT = 17;
`endif

  logic           clk, rst_n;
  logic           cfg_valid, cfg_ready;
  logic [CAP-1:0] cfg_mask;
  logic           rot_en;
  logic [15:0]    rot_period;
  logic [CAP-1:0] sw;
  logic           sw_update, cfg_err, busy;

  int checks = 0;
  int failures = 0;

  logic [CAP-1:0] D, M, MR, ILL;

  sw_mask_sched dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_mask(cfg_mask),
    .rot_en(rot_en), .rot_period(rot_period),
    .sw(sw), .sw_update(sw_update), .cfg_err(cfg_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_mask = '0; rot_en = 1'b0; rot_period = '0;
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    step();
    checks++; if (sw !== D) begin failures++; $display("FAIL reset_sw got=%h exp=%h", sw, D); end
    checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", cfg_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if ({sw_update, cfg_err} !== 2'b00) begin failures++; $display("FAIL reset_pulses got=%b exp=00", {sw_update, cfg_err}); end
  endtask

  task automatic test_legal();
    int first_n, upd_n, busy_n, err_n;
    logic upd_at_lat;
    logic [CAP-1:0] mid;
    first_n = -1; upd_n = 0; busy_n = 0; err_n = 0; upd_at_lat = 1'b0; mid = '0;
    cfg_mask = M; cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    checks++; if ({busy, cfg_ready} !== 2'b10) begin failures++; $display("FAIL legal_accept busy_ready got=%b exp=10", {busy, cfg_ready}); end
    busy_n = busy ? 1 : 0;
    for (int n = 1; n <= 30; n++) begin
      step();
      if (sw === M && first_n < 0) first_n = n;
      if (sw_update) upd_n++;
      if (busy) busy_n++;
      if (cfg_err) err_n++;
      if (n == LAT) upd_at_lat = sw_update;
      if (n == LAT - 1) mid = sw;
    end
    checks++; if (first_n != LAT) begin failures++; $display("FAIL legal_latency got=%0d exp=%0d", first_n, LAT); end
`ifdef SW_MASK_SCHED_BBM_EN
    checks++; if (upd_n != 2) begin failures++; $display("FAIL legal_upd_count got=%0d exp=2", upd_n); end
    checks++; if (mid !== (D & M)) begin failures++; $display("FAIL bbm_intermediate got=%h exp=%h", mid, D & M); end
`else
    checks++; if (upd_n != 1) begin failures++; $display("FAIL legal_upd_count got=%0d exp=1", upd_n); end
    checks++; if (mid !== D) begin failures++; $display("FAIL legal_pre_commit got=%h exp=%h", mid, D); end
`endif
    checks++; if (upd_at_lat !== 1'b1) begin failures++; $display("FAIL legal_upd_edge got=%b exp=1", upd_at_lat); end
    checks++; if (busy_n != LAT + 4) begin failures++; $display("FAIL legal_busy_cycles got=%0d exp=%0d", busy_n, LAT + 4); end
    checks++; if (err_n != 0) begin failures++; $display("FAIL legal_no_err got=%0d exp=0", err_n); end
    checks++; if ({sw === M, cfg_ready} !== 2'b11) begin failures++; $display("FAIL legal_final sw=%h ready=%b", sw, cfg_ready); end
  endtask

  task automatic test_illegal();
    int err_n, err_at, upd_n;
    err_n = 0; err_at = -1; upd_n = 0;
    cfg_mask = ILL; cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    for (int n = 1; n <= 25; n++) begin
      step();
      if (cfg_err) begin err_n++; if (err_at < 0) err_at = n; end
      if (sw_update) upd_n++;
      if (n == 16) begin
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL illegal_idle got=%b exp=0", busy); end
      end
    end
    checks++; if (err_n != 1) begin failures++; $display("FAIL illegal_err_count got=%0d exp=1", err_n); end
    checks++; if (err_at != 16) begin failures++; $display("FAIL illegal_err_edge got=%0d exp=16", err_at); end
    checks++; if (upd_n != 0) begin failures++; $display("FAIL illegal_no_update got=%0d exp=0", upd_n); end
    checks++; if (sw !== M) begin failures++; $display("FAIL illegal_sw_kept got=%h exp=%h", sw, M); end
  endtask

  task automatic test_rotation();
    logic [CAP-1:0] exp_sw;
    do_reset();
    rot_en = 1'b1; rot_period = 16'd3;
    exp_sw = D;
    for (int k = 1; k <= 59; k++) begin
      for (int e = 1; e <= 3; e++) begin
        step();
        checks++;
        if (sw_update !== (e == 3)) begin failures++; $display("FAIL rot_update k=%0d e=%0d got=%b", k, e, sw_update); end
      end
      exp_sw = {exp_sw[CAP-2:0], exp_sw[CAP-1]};
      checks++; if (sw !== exp_sw) begin failures++; $display("FAIL rot_sw k=%0d got=%h exp=%h", k, sw, exp_sw); end
      checks++; if ($countones(sw) != 70) begin failures++; $display("FAIL rot_popcount k=%0d got=%0d exp=70", k, $countones(sw)); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rot_busy k=%0d got=%b exp=0", k, busy); end
      if (k == 58) begin
        checks++; if (sw !== M) begin failures++; $display("FAIL rot_58 got=%h exp=%h", sw, M); end
      end
    end
    checks++; if (sw !== MR) begin failures++; $display("FAIL rot_wrap got=%h exp=%h", sw, MR); end
    rot_en = 1'b0;
  endtask

  task automatic test_accept_vs_rot();
    logic exp_upd;
    do_reset();
    rot_en = 1'b1; rot_period = 16'd3;
    step(); step();
    cfg_mask = M; cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    checks++; if ({sw === D, sw_update, busy} !== 3'b101) begin failures++; $display("FAIL tie_accept sw=%h upd=%b busy=%b", sw, sw_update, busy); end
    for (int n = 1; n <= LAT + 7; n++) begin
      step();
`ifdef SW_MASK_SCHED_BBM_EN
      exp_upd = (n == LAT - 1) || (n == LAT) || (n == LAT + 7);
`else
      exp_upd = (n == LAT) || (n == LAT + 7);
`endif
      checks++; if (sw_update !== exp_upd) begin failures++; $display("FAIL tie_update n=%0d got=%b exp=%b", n, sw_update, exp_upd); end
      if (n == LAT + 6) begin
        checks++; if (sw !== M) begin failures++; $display("FAIL tie_commit got=%h exp=%h", sw, M); end
      end
    end
    checks++; if (sw !== MR) begin failures++; $display("FAIL tie_resume got=%h exp=%h", sw, MR); end
    rot_en = 1'b0;
  endtask

  task automatic test_reset_mid_count();
    int bad;
    bad = 0;
    cfg_mask = ILL ^ M; cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    for (int n = 0; n < 5; n++) step();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (sw !== D) begin failures++; $display("FAIL midrst_sw got=%h exp=%h", sw, D); end
    checks++; if ({busy, cfg_ready, sw_update, cfg_err} !== 4'b0100) begin failures++; $display("FAIL midrst_flags got=%b exp=0100", {busy, cfg_ready, sw_update, cfg_err}); end
    step();
    rst_n = 1'b1;
    for (int n = 0; n < 20; n++) begin
      step();
      if (sw_update || cfg_err || busy) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL midrst_quiet got=%0d exp=0", bad); end
    checks++; if (sw !== D) begin failures++; $display("FAIL midrst_final got=%h exp=%h", sw, D); end
  endtask

  initial begin
    D = '0; M = '0; ILL = '0;
    for (int i = 0; i < 70; i++) D[i] = 1'b1;
    for (int i = 58; i < 128; i++) M[i] = 1'b1;
    for (int i = 0; i < 71; i++) ILL[i] = 1'b1;
    MR = M;
    MR[58] = 1'b0;
    MR[0]  = 1'b1;
    test_reset();
    test_legal();
    test_illegal();
    test_rotation();
    test_accept_vs_rot();
    test_reset_mid_count();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
